mbox_rr_mux: RTL and testbench
==============================

Name: mbox_rr_mux

Overview:
N-port request multiplexer in front of the shared mailbox register slave. It arbitrates CPU requests with a true round-robin policy: idle requesters are skipped in one cycle, so there is no per-slot polling. It forwards the winner's address, data and write strobe to the slave, then returns read data, acknowledge and error to that CPU only. A timeout counter protects the CPUs from a slave that never acknowledges.

Parameters:
W_WIDTH_SYS, 32, address/data width.
N_NUMB_CPU, 4, number of CPU ports (2..16, need not be a power of two).
T_TIMEOUT, 255, cycles in BUSY without slave ack before the transaction is aborted with error (1..65535).
W_IDX (localparam), $clog2(N_NUMB_CPU), grant index width.

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
req_i  input  [N_NUMB_CPU-1:0]  per-CPU request level, held until ack
addr_i  input  [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0]  per-CPU address
data_i  input  [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0]  per-CPU write data
write_i  input  [N_NUMB_CPU-1:0]  per-CPU write (1) / read (0)
mux_ack_o  output  [N_NUMB_CPU-1:0]  one-cycle ack pulse to granted CPU
mux_rdata_o  output  [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0]  per-CPU read data, held until that CPU's next transaction
mux_err_o  output  [N_NUMB_CPU-1:0]  one-cycle error pulse, coincident with mux_ack_o
mux_req_o  output  1  request to slave
mux_addr_o  output  W_WIDTH_SYS  address to slave
mux_data_o  output  W_WIDTH_SYS  write data to slave
mux_write_o  output  1  write strobe to slave
mux_numb_cpu_o  output  32  index of the granted CPU, zero-extended
slv_ack_i  input  1  slave completion, one-cycle pulse
slv_rdata_i  input  W_WIDTH_SYS  slave read data, valid with slv_ack_i
slv_err_i  input  1  slave error, valid with slv_ack_i

Behaviour:
- Reset (rstn low, asynchronous):
  - all outputs 0, state IDLE, last-grant pointer = N_NUMB_CPU-1 (so CPU0 wins first), timeout counter 0.
  - Reset asserted mid-transaction aborts it silently; no ack/err is issued.
- States: IDLE, BUSY, RESP, RELEASE.
- IDLE:
  - If any req_i is set, grant g = first set index scanning last+1, last+2, ... with wrap modulo N_NUMB_CPU.
  - Next cycle: mux_req_o=1; addr/data/write latched from port g; mux_numb_cpu_o=g; last=g; state BUSY.
  - Request-to-slave latency is 1 cycle.
- BUSY:
  - Outputs to the slave are held stable.
  - Counter increments each cycle.
  - On slv_ack_i: mux_req_o=0; mux_rdata_o[g]=slv_rdata_i on reads only (unchanged on writes); mux_err_o[g]=slv_err_i; mux_ack_o[g]=1; state RESP.
  - If the counter reaches T_TIMEOUT with no ack: mux_req_o=0; mux_err_o[g]=1; mux_ack_o[g]=1; rdata unchanged; state RESP.
  - If ack and timeout coincide, the ack wins.
  - If req_i[g] drops before ack (protocol violation): mux_req_o=0, no ack, state IDLE.
- RESP:
  - Lasts one cycle; ack/err return to 0; counter cleared.
  - If req_i[g]=0, go to IDLE; otherwise go to RELEASE.
- RELEASE: wait until req_i[g]=0, then IDLE. This prevents the same level request being served twice.
- Fairness: a CPU waits at most N_NUMB_CPU-1 transactions. Simultaneous requests are resolved purely by the pointer.
- Only one mux_ack_o bit is ever high in a cycle.

Decomposition:
- Package mbox_pkg holds:
  - the state enum typedef (logic [1:0]: IDLE, BUSY, RESP, RELEASE);
  - the function clog2-safe idx width;
  - the constant MBOX_CPU_IDX_W=32 for mux_numb_cpu_o.
- Sub-module mbox_rr_pick: combinational. Inputs are req vector and last pointer; outputs are grant index and valid. It is parametrised by N_NUMB_CPU, implemented as a doubled-vector priority encoder.

Test Plan:
- Reset then req_i=4'b0001 read addr 0x10, slave ack with rdata 0xCAFE after 3 cycles → mux_req_o high from cycle 1; mux_ack_o=4'b0001 one cycle; mux_rdata_o[0]=0xCAFE; mux_numb_cpu_o=0.
- req_i=4'b1111 held, each CPU dropping req after its ack, slave acking after 1 cycle → grant order 0,1,2,3,0; no CPU granted twice in a row.
- last grant 1, req_i=4'b1001 → CPU3 granted next, not CPU0 (wrap/skip); mux_numb_cpu_o=3.
- Slave never acks, T_TIMEOUT=8 → after 8 BUSY cycles, mux_err_o[g]=1 and mux_ack_o[g]=1 for one cycle; mux_req_o=0; rdata unchanged.
- CPU2 write 0x1234 to addr 0x4 with slv_err_i=1 on ack → mux_data_o=0x1234, mux_write_o=1; mux_err_o=4'b0100 pulse; mux_rdata_o[2] unchanged.
- rstn pulled low in BUSY → all outputs 0 immediately (asynchronous); after release CPU0 has priority; no stray ack.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared types and helpers for the mailbox round-robin request mux.
package mbox_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } mbox_state_e;

  // Width of the CPU index driven to the slave side.
  localparam int MBOX_CPU_IDX_W = 32;

  // Index width that stays at least 1 bit for degenerate port counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbox_rr_pick.sv
// Round-robin pick: first set request after 'last', wrapping, in one pass.
module mbox_rr_pick
  import mbox_pkg::*;
#(
  parameter  int N_NUMB_CPU = 4,
  localparam int W_IDX      = idx_w(N_NUMB_CPU)
) (
  input  logic [N_NUMB_CPU-1:0] req,
  input  logic [W_IDX-1:0]      last,
  output logic [W_IDX-1:0]      grant,
  output logic                  vld
);

  logic [2*N_NUMB_CPU-1:0] dbl;
  logic [N_NUMB_CPU-1:0]   rot;
  logic [W_IDX:0]          base;
  logic [W_IDX+1:0]        sum;

  assign dbl = {req, req};

  // Rotate the doubled vector so index last+1 lands at bit 0, then take the
  // lowest set bit and map it back into the 0..N-1 range.
  always_comb begin
    base = {1'b0, last} + 1'b1;
    rot  = N_NUMB_CPU'(dbl >> base);
    vld  = 1'b0;
    sum  = '0;
    for (int i = N_NUMB_CPU - 1; i >= 0; i--) begin
      if (rot[i]) begin
        vld = 1'b1;
        sum = (W_IDX+2)'(base) + (W_IDX+2)'(i);
      end
    end
    if (sum >= (W_IDX+2)'(N_NUMB_CPU)) sum = sum - (W_IDX+2)'(N_NUMB_CPU);
    grant = sum[W_IDX-1:0];
  end

endmodule

// File: rtl/mbox_rr_mux.sv
// N-port round-robin request mux in front of the mailbox register slave.
module mbox_rr_mux
  import mbox_pkg::*;
#(
  parameter  int W_WIDTH_SYS = 32,
  parameter  int N_NUMB_CPU  = 4,
  parameter  int T_TIMEOUT   = 255,
  localparam int W_IDX       = idx_w(N_NUMB_CPU)
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [N_NUMB_CPU-1:0]                  req_i,
  input  logic [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0] addr_i,
  input  logic [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0] data_i,
  input  logic [N_NUMB_CPU-1:0]                  write_i,
  output logic [N_NUMB_CPU-1:0]                  mux_ack_o,
  output logic [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0] mux_rdata_o,
  output logic [N_NUMB_CPU-1:0]                  mux_err_o,
  output logic                                   mux_req_o,
  output logic [W_WIDTH_SYS-1:0]                 mux_addr_o,
  output logic [W_WIDTH_SYS-1:0]                 mux_data_o,
  output logic                                   mux_write_o,
  output logic [MBOX_CPU_IDX_W-1:0]              mux_numb_cpu_o,
  input  logic                                   slv_ack_i,
  input  logic [W_WIDTH_SYS-1:0]                 slv_rdata_i,
  input  logic                                   slv_err_i
);

  localparam int CNT_W = 16;

  mbox_state_e      state, state_nxt;
  logic [W_IDX-1:0] last, g, pick_g;
  logic             pick_vld;
  logic [CNT_W-1:0] cnt;
  logic             timeout;

  assign timeout        = (cnt == CNT_W'(T_TIMEOUT - 1));
  assign mux_numb_cpu_o = MBOX_CPU_IDX_W'(g);

  mbox_rr_pick #(.N_NUMB_CPU(N_NUMB_CPU)) u_pick (
    .req   (req_i),
    .last  (last),
    .grant (pick_g),
    .vld   (pick_vld)
  );

  // State register; reset also aborts any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state. Ack beats a dropped request, which beats the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = BUSY;
      BUSY: begin
        if (slv_ack_i)      state_nxt = RESP;
        else if (!req_i[g]) state_nxt = IDLE;
        else if (timeout)   state_nxt = RESP;
      end
      RESP:    state_nxt = req_i[g] ? RELEASE : IDLE;
      RELEASE: if (!req_i[g]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, slave-side drive, response return and timeout counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last        <= W_IDX'(N_NUMB_CPU - 1);
      g           <= '0;
      cnt         <= '0;
      mux_req_o   <= 1'b0;
      mux_addr_o  <= '0;
      mux_data_o  <= '0;
      mux_write_o <= 1'b0;
      mux_ack_o   <= '0;
      mux_err_o   <= '0;
      mux_rdata_o <= '0;
    end else begin
      mux_ack_o <= '0;
      mux_err_o <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            g           <= pick_g;
            last        <= pick_g;
            mux_req_o   <= 1'b1;
            mux_addr_o  <= addr_i[pick_g];
            mux_data_o  <= data_i[pick_g];
            mux_write_o <= write_i[pick_g];
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (slv_ack_i) begin
            mux_req_o    <= 1'b0;
            mux_ack_o[g] <= 1'b1;
            mux_err_o[g] <= slv_err_i;
            if (!mux_write_o) mux_rdata_o[g] <= slv_rdata_i;
          end else if (!req_i[g]) begin
            mux_req_o <= 1'b0;
          end else if (timeout) begin
            mux_req_o    <= 1'b0;
            mux_ack_o[g] <= 1'b1;
            mux_err_o[g] <= 1'b1;
          end
        end
        RESP:    cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mbox_rr_mux.sv
// Directed bench for the mailbox round-robin mux (N=4, timeout 8).
module tb_mbox_rr_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]         req_i, write_i;
  logic [N-1:0][W-1:0]  addr_i, data_i;
  logic [N-1:0]         mux_ack_o, mux_err_o;
  logic [N-1:0][W-1:0]  mux_rdata_o;
  logic             mux_req_o, mux_write_o;
  logic [W-1:0]     mux_addr_o, mux_data_o;
  logic [31:0]      mux_numb_cpu_o;
  logic             slv_ack_i, slv_err_i;
  logic [W-1:0]     slv_rdata_i;

  int total = 0;
  int bad   = 0;

  mbox_rr_mux #(.W_WIDTH_SYS(W), .N_NUMB_CPU(N), .T_TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn), .req_i(req_i), .addr_i(addr_i), .data_i(data_i),
    .write_i(write_i), .mux_ack_o(mux_ack_o), .mux_rdata_o(mux_rdata_o),
    .mux_err_o(mux_err_o), .mux_req_o(mux_req_o), .mux_addr_o(mux_addr_o),
    .mux_data_o(mux_data_o), .mux_write_o(mux_write_o),
    .mux_numb_cpu_o(mux_numb_cpu_o), .slv_ack_i(slv_ack_i),
    .slv_rdata_i(slv_rdata_i), .slv_err_i(slv_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bounded wait for the slave request; an expired bound shows as a FAIL.
  task automatic wait_req(input string tag);
    int n = 0;
    while (!mux_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(mux_req_o), 32'd1);
  endtask

  // Called on a negedge in BUSY cycle 1; acks during BUSY cycle 'lat'.
  task automatic serve(input int lat, input logic [31:0] rd, input logic er);
    repeat (lat - 1) @(negedge clk);
    slv_ack_i = 1'b1; slv_rdata_i = rd; slv_err_i = er;
    @(negedge clk);
    slv_ack_i = 1'b0; slv_rdata_i = '0; slv_err_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gx;
    rstn = 1'b0; req_i = '0; write_i = '0; addr_i = '0; data_i = '0;
    slv_ack_i = 1'b0; slv_rdata_i = '0; slv_err_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req",  32'(mux_req_o), 32'd0);
    chk("rst_ack",  32'(mux_ack_o), 32'd0);
    chk("rst_err",  32'(mux_err_o), 32'd0);
    chk("rst_numb", mux_numb_cpu_o, 32'd0);
    chk("rst_rd0",  mux_rdata_o[0], 32'd0);

    // single read from CPU0
    rstn = 1'b1;
    req_i = 4'b0001; addr_i[0] = 32'h10;
    @(negedge clk);
    chk("t1_req",   32'(mux_req_o), 32'd1);
    chk("t1_numb",  mux_numb_cpu_o, 32'd0);
    chk("t1_addr",  mux_addr_o, 32'h10);
    chk("t1_wr",    32'(mux_write_o), 32'd0);
    serve(3, 32'hCAFE, 1'b0);
    chk("t1_ack",   32'(mux_ack_o), 32'b0001);
    chk("t1_err",   32'(mux_err_o), 32'd0);
    chk("t1_req0",  32'(mux_req_o), 32'd0);
    chk("t1_rd0",   mux_rdata_o[0], 32'hCAFE);
    req_i = '0;
    @(negedge clk);
    chk("t1_pulse", 32'(mux_ack_o), 32'd0);

    // all four requesting: order 0,1,2,3,0 from a fresh pointer
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_req("t2");
      gx = k % 4;
      chk("t2_numb", mux_numb_cpu_o, 32'(gx));
      serve(1, 32'hA0 + 32'(gx), 1'b0);
      chk("t2_ack", 32'(mux_ack_o), 32'(1 << gx));
      if (k < 4) begin
        req_i[gx] = 1'b0;
        @(negedge clk);
        req_i[gx] = 1'b1;
      end else begin
        req_i = '0;
        @(negedge clk);
      end
    end
    chk("t2_rd2", mux_rdata_o[2], 32'hA2);

    // pointer at 1, requests 0 and 3: CPU3 wins, then CPU0
    req_i = 4'b0010;
    wait_req("t3a");
    chk("t3_numb1", mux_numb_cpu_o, 32'd1);
    serve(1, 32'hB1, 1'b0);
    req_i = '0;
    @(negedge clk);
    req_i = 4'b1001;
    wait_req("t3b");
    chk("t3_numb3", mux_numb_cpu_o, 32'd3);
    serve(1, 32'hB3, 1'b0);
    chk("t3_ack3", 32'(mux_ack_o), 32'b1000);
    req_i[3] = 1'b0;
    @(negedge clk);
    wait_req("t3c");
    chk("t3_numb0", mux_numb_cpu_o, 32'd0);
    serve(2, 32'hB0, 1'b0);
    chk("t3_ack0", 32'(mux_ack_o), 32'b0001);
    chk("t3_rd0",  mux_rdata_o[0], 32'hB0);
    chk("t3_rd3",  mux_rdata_o[3], 32'hB3);
    req_i = '0;
    @(negedge clk);

    // slave never answers: abort after 8 BUSY cycles
    req_i = 4'b0100;
    wait_req("t4");
    n = 0;
    while (mux_req_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t4_busy", 32'(n), 32'd8);
    chk("t4_ack",  32'(mux_ack_o), 32'b0100);
    chk("t4_err",  32'(mux_err_o), 32'b0100);
    chk("t4_rd2",  mux_rdata_o[2], 32'hA2);
    req_i = '0;
    @(negedge clk);
    chk("t4_pulse", 32'(mux_ack_o | mux_err_o), 32'd0);

    // CPU2 write with slave error: rdata must not change
    req_i = 4'b0100; write_i = 4'b0100; addr_i[2] = 32'h4; data_i[2] = 32'h1234;
    wait_req("t5");
    chk("t5_numb", mux_numb_cpu_o, 32'd2);
    chk("t5_addr", mux_addr_o, 32'h4);
    chk("t5_data", mux_data_o, 32'h1234);
    chk("t5_wr",   32'(mux_write_o), 32'd1);
    serve(2, 32'hDEAD, 1'b1);
    chk("t5_ack",  32'(mux_ack_o), 32'b0100);
    chk("t5_err",  32'(mux_err_o), 32'b0100);
    chk("t5_rd2",  mux_rdata_o[2], 32'hA2);
    req_i = '0; write_i = '0;
    @(negedge clk);

    // asynchronous reset in the middle of a transaction
    req_i = 4'b0010;
    wait_req("t6a");
    chk("t6_numb1", mux_numb_cpu_o, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_req",  32'(mux_req_o), 32'd0);
    chk("t6_numb", mux_numb_cpu_o, 32'd0);
    chk("t6_rd1",  mux_rdata_o[1], 32'd0);
    @(negedge clk);
    req_i = 4'b0011;
    @(negedge clk);
    chk("t6_noack", 32'(mux_ack_o), 32'd0);
    rstn = 1'b1;
    wait_req("t6b");
    chk("t6_numb0", mux_numb_cpu_o, 32'd0);
    chk("t6_stray", 32'(mux_ack_o), 32'd0);
    serve(1, 32'h77, 1'b0);
    chk("t6_ack0", 32'(mux_ack_o), 32'b0001);
    req_i = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
